// File: rtl/rep_pkg.sv
// ---------------------------------------------------------------------------
// rep_pkg
//   Shared definitions for the bit repeater / derepeater pair.
//   - clog2 and width helpers used to size the chip, ones and bit counters
//   - default parameter values and the widths derived from them
//   - TIE_VALUE: the bit decided when an even repeat count splits evenly
//   - decide_bit: majority decision on a count of '1' chips
//   - state_e: derepeater word FSM states
// ---------------------------------------------------------------------------
package rep_pkg;

  // Bit decided when exactly half the chips are '1' (even N_REPT only).
  localparam logic TIE_VALUE = 1'b0;

  localparam int DEF_N_REPT     = 3;
  localparam int DEF_N_BITS_OUT = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Counter holding 0..n-1, never narrower than one bit.
  function automatic int count_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Counter holding 0..n inclusive.
  function automatic int ones_width(input int n);
    return (clog2(n + 1) < 1) ? 1 : clog2(n + 1);
  endfunction

  localparam int DEF_CHIP_W = count_width(DEF_N_REPT);
  localparam int DEF_ONES_W = ones_width(DEF_N_REPT);
  localparam int DEF_BIT_W  = count_width(DEF_N_BITS_OUT);

  // Majority vote of 'ones' out of 'n' chips.
  function automatic logic decide_bit(input int ones, input int n);
    if (2 * ones == n) return TIE_VALUE;
    return (2 * ones > n);
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

endpackage

// File: rtl/data_derepeater_if.sv
// ---------------------------------------------------------------------------
// data_derepeater_if
//   Chip-stream input and recovered-word output of the derepeater.
//   i_valid  chip present this cycle
//   i_bit    received chip
//   i_sync   frame start; aborts any partial word
//   o_bits   last completed word, MSB = first bit received
//   o_valid  one-cycle pulse when o_bits/o_error update
//   o_error  some bit of the word had non-unanimous chips
//   master: the chip source (drives i_*), slave: the derepeater.
// ---------------------------------------------------------------------------
interface data_derepeater_if #(
  parameter int N_BITS_OUT = 8
);
  logic                  i_valid;
  logic                  i_bit;
  logic                  i_sync;
  logic [N_BITS_OUT-1:0] o_bits;
  logic                  o_valid;
  logic                  o_error;

  modport master (
    output i_valid, i_bit, i_sync,
    input  o_bits, o_valid, o_error
  );

  modport slave (
    input  i_valid, i_bit, i_sync,
    output o_bits, o_valid, o_error
  );
endinterface

// File: rtl/rep_majority_voter.sv
// ---------------------------------------------------------------------------
// rep_majority_voter
//   Counts chips of the current payload bit and votes on the last one.
//   clk, rst   clock, synchronous active-high reset
//   sync       restart: the chip of this cycle (if valid) is chip 0
//   valid      chip present
//   chip       chip value
//   bit_done   this cycle's chip completes a bit (combinational)
//   bit_value  majority decision for that bit
//   bit_mixed  the bit's chips were not unanimous
// ---------------------------------------------------------------------------
module rep_majority_voter
  import rep_pkg::*;
#(
  parameter int N_REPT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic valid,
  input  logic chip,
  output logic bit_done,
  output logic bit_value,
  output logic bit_mixed
);

  localparam int CHIP_W = count_width(N_REPT);
  localparam int ONES_W = ones_width(N_REPT);

  logic [CHIP_W-1:0] chip_q;
  logic [CHIP_W-1:0] chip_eff;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_eff;
  logic [ONES_W-1:0] ones_next;

  // A sync cycle sees the counters as already cleared, so its own chip
  // is counted as chip 0 rather than continuing the aborted bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path; assigning defaults first keeps latches from being inferred.
    chip_eff  = '0;
    ones_eff  = '0;
    if (!sync) begin
      chip_eff = chip_q;
      ones_eff = ones_q;
    end
    ones_next = ones_eff + ONES_W'(chip);
    bit_done  = valid && (chip_eff == CHIP_W'(N_REPT - 1));
    bit_value = decide_bit(int'(ones_next), N_REPT);
    bit_mixed = (ones_next != '0) && (ones_next != ONES_W'(N_REPT));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_q <= '0;
      ones_q <= '0;
    end else if (valid) begin
      if (bit_done) begin
        chip_q <= '0;
        ones_q <= '0;
      end else begin
        chip_q <= chip_eff + CHIP_W'(1);
        ones_q <= ones_next;
      end
    end else if (sync) begin
      chip_q <= '0;
      ones_q <= '0;
    end
  end

endmodule

// File: rtl/data_derepeater.sv
// ---------------------------------------------------------------------------
// data_derepeater
//   Recovers words from a chip stream where each payload bit is repeated
//   N_REPT times, MSB first. Bits are decided by majority vote and packed
//   into N_BITS_OUT-bit words presented with a one-cycle o_valid pulse.
//   i_clock  system clock (rising edge)
//   i_reset  synchronous active-high reset, highest priority
//   bus      data_derepeater_if.slave: i_valid/i_bit/i_sync in,
//            o_bits/o_valid/o_error out
// ---------------------------------------------------------------------------
module data_derepeater
  import rep_pkg::*;
#(
  parameter int N_REPT     = 3,
  parameter int N_BITS_OUT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  data_derepeater_if.slave   bus
);

  localparam int BIT_W = count_width(N_BITS_OUT);

  logic                  bit_done;
  logic                  bit_value;
  logic                  bit_mixed;

  logic [BIT_W-1:0]      bit_q;
  logic [BIT_W-1:0]      bit_eff;
  logic                  err_q;
  logic                  err_eff;
  logic                  err_next;
  logic [N_BITS_OUT-1:0] shift_q;
  logic [N_BITS_OUT-1:0] shift_next;
  logic                  word_done;

  logic [N_BITS_OUT-1:0] bits_q;
  logic                  error_q;

  state_e                state_q;
  state_e                state_d;

  rep_majority_voter #(
    .N_REPT (N_REPT)
  ) u_voter (
    .clk       (i_clock),
    .rst       (i_reset),
    .sync      (bus.i_sync),
    .valid     (bus.i_valid),
    .chip      (bus.i_bit),
    .bit_done  (bit_done),
    .bit_value (bit_value),
    .bit_mixed (bit_mixed)
  );

  // Word assembly. As in the voter, a sync cycle starts from cleared
  // counters, so a word can never complete on the cycle it is aborted.
  always_comb begin
    bit_eff    = '0;
    err_eff    = 1'b0;
    if (!bus.i_sync) begin
      bit_eff = bit_q;
      err_eff = err_q;
    end
    // Truncating cast keeps the low N_BITS_OUT bits: the first bit
    // received drifts up to the MSB as later bits enter at the LSB.
    shift_next = N_BITS_OUT'({shift_q, bit_value});
    err_next   = err_eff | bit_mixed;
    word_done  = bit_done && (bit_eff == BIT_W'(N_BITS_OUT - 1));
  end

  // Word FSM: ACCUM while collecting, EMIT for the single pulse cycle.
  // Chips keep being accepted in EMIT. Staying in EMIT is only possible
  // when a whole word is a single chip (N_REPT = N_BITS_OUT = 1).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (word_done) state_d = EMIT;
      EMIT:    state_d = word_done ? EMIT : ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bit_q   <= '0;
      err_q   <= 1'b0;
      shift_q <= '0;
      bits_q  <= '0;
      error_q <= 1'b0;
    end else if (bit_done) begin
      shift_q <= shift_next;
      if (word_done) begin
        bit_q   <= '0;
        err_q   <= 1'b0;
        bits_q  <= shift_next;
        error_q <= err_next;
      end else begin
        bit_q <= bit_eff + BIT_W'(1);
        err_q <= err_next;
      end
    end else if (bus.i_sync) begin
      bit_q <= '0;
      err_q <= 1'b0;
    end
  end

  assign bus.o_bits  = bits_q;
  assign bus.o_error = error_q;
  assign bus.o_valid = (state_q == EMIT);

endmodule

// File: tb/tb_data_derepeater.sv
// ---------------------------------------------------------------------------
// tb_data_derepeater
//   Two derepeaters (N_REPT=3/N_BITS_OUT=4 and N_REPT=2/N_BITS_OUT=2) are
//   driven with the same chip stream. A reference model keeps the chips
//   received since the last sync/reset/completed word and decodes a word
//   by counting ones per group once enough chips have arrived. Outputs of
//   both instances are compared every cycle; directed scenarios add
//   checks against fixed expected words.
// ---------------------------------------------------------------------------
module tb_data_derepeater;
  import rep_pkg::*;

  localparam int NR_A = 3;
  localparam int NB_A = 4;
  localparam int NR_B = 2;
  localparam int NB_B = 2;

  typedef struct {
    logic        valid;
    logic [31:0] bits;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  data_derepeater_if #(.N_BITS_OUT(NB_A)) if_a ();
  data_derepeater_if #(.N_BITS_OUT(NB_B)) if_b ();

  data_derepeater #(.N_REPT(NR_A), .N_BITS_OUT(NB_A)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (if_a.slave)
  );

  data_derepeater #(.N_REPT(NR_B), .N_BITS_OUT(NB_B)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (if_b.slave)
  );

  int   checks;
  int   errors;
  int   pulses_a;
  int   pulses_b;
  bit   q_a[$];
  bit   q_b[$];
  exp_t ex_a;
  exp_t ex_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Decode a complete chip list: count ones per group of nr chips.
  function automatic void decode(input bit q[$], input int nr, input int nb,
                                 output logic [31:0] w, output logic e);
    w = '0;
    e = 1'b0;
    for (int k = 0; k < nb; k++) begin
      int   ones;
      logic b;
      ones = 0;
      for (int j = 0; j < nr; j++) ones += int'(q[k * nr + j]);
      if (2 * ones > nr)       b = 1'b1;
      else if (2 * ones == nr) b = TIE_VALUE;
      else                     b = 1'b0;
      w = (w << 1) | 32'(b);
      if (ones != 0 && ones != nr) e = 1'b1;
    end
  endfunction

  function automatic void model(inout bit q[$], inout exp_t ex,
                                input int nr, input int nb,
                                input logic v, input logic b,
                                input logic s, input logic r);
    ex.valid = 1'b0;
    if (r) begin
      q.delete();
      ex.bits = '0;
      ex.err  = 1'b0;
    end else begin
      if (s) q.delete();
      if (v) begin
        q.push_back(b);
        if (q.size() == nr * nb) begin
          decode(q, nr, nb, ex.bits, ex.err);
          ex.valid = 1'b1;
          q.delete();
        end
      end
    end
  endfunction

  // One cycle: check outputs of the previous edge, then apply new inputs.
  task automatic step(input logic v, input logic b, input logic s,
                      input logic r);
    @(negedge clk);
    check("a_valid", 32'(if_a.o_valid), 32'(ex_a.valid));
    check("a_bits",  32'(if_a.o_bits),  ex_a.bits);
    check("a_error", 32'(if_a.o_error), 32'(ex_a.err));
    check("b_valid", 32'(if_b.o_valid), 32'(ex_b.valid));
    check("b_bits",  32'(if_b.o_bits),  ex_b.bits);
    check("b_error", 32'(if_b.o_error), 32'(ex_b.err));
    if (if_a.o_valid) pulses_a++;
    if (if_b.o_valid) pulses_b++;
    rst          = r;
    if_a.i_valid = v;
    if_a.i_bit   = b;
    if_a.i_sync  = s;
    if_b.i_valid = v;
    if_b.i_bit   = b;
    if_b.i_sync  = s;
    model(q_a, ex_a, NR_A, NB_A, v, b, s, r);
    model(q_b, ex_b, NR_B, NB_B, v, b, s, r);
  endtask

  // Send a string of '0'/'1' chips with 0..max_gap idle cycles before
  // each; optionally raise i_sync with the first chip. Ends with one idle
  // cycle so the outputs of the last chip are visible on return.
  task automatic send_chips(input string chips, input int max_gap,
                            input bit sync_first);
    for (int i = 0; i < chips.len(); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, 1'b0);
      step(1'b1, chips[i] == "1", sync_first && (i == 0), 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pulses_a     = 0;
    pulses_b     = 0;
    ex_a         = '{valid: 1'b0, bits: '0, err: 1'b0};
    ex_b         = '{valid: 1'b0, bits: '0, err: 1'b0};
    rst          = 1'b1;
    if_a.i_valid = 1'b0;
    if_a.i_bit   = 1'b0;
    if_a.i_sync  = 1'b0;
    if_b.i_valid = 1'b0;
    if_b.i_bit   = 1'b0;
    if_b.i_sync  = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_bits",  32'(if_a.o_bits),  32'h0);
    check("reset_valid", 32'(if_a.o_valid), 32'h0);
    check("reset_error", 32'(if_a.o_error), 32'h0);

    // Clean word, contiguous chips.
    send_chips("111000111000", 0, 1'b0);
    check("clean_valid", 32'(if_a.o_valid), 32'h1);
    check("clean_bits",  32'(if_a.o_bits),  32'hA);
    check("clean_error", 32'(if_a.o_error), 32'h0);

    // Single flipped chip is corrected but flagged.
    send_chips("110000111000", 0, 1'b0);
    check("flip1_bits",  32'(if_a.o_bits),  32'hA);
    check("flip1_error", 32'(if_a.o_error), 32'h1);

    // Two flipped chips in bit 1 overturn the vote.
    send_chips("111110111000", 0, 1'b0);
    check("flip2_bits",  32'(if_a.o_bits),  32'hE);
    check("flip2_error", 32'(if_a.o_error), 32'h1);

    // Words 5 then C with random gaps; o_bits holds 5 in between.
    pulses_a = 0;
    send_chips({"000111000111", "111111000000"}, 5, 1'b1);
    check("gap_pulses", 32'(pulses_a),      32'd2);
    check("gap_bits",   32'(if_a.o_bits),   32'hC);

    // Sync abort after 7 chips, then a full word 3.
    send_chips("1011101", 2, 1'b1);
    pulses_a = 0;
    send_chips("000000111111", 0, 1'b1);
    check("sync_pulses", 32'(pulses_a),     32'd1);
    check("sync_bits",   32'(if_a.o_bits),  32'h3);

    // Reset mid-word returns the outputs to 0.
    send_chips("11100", 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_bits",  32'(if_a.o_bits),  32'h0);
    check("midrst_error", 32'(if_a.o_error), 32'h0);

    // Even repeat count: "10" ties to 0, "11" gives 1.
    send_chips("1011", 0, 1'b0);
    check("tie_valid", 32'(if_b.o_valid), 32'h1);
    check("tie_bits",  32'(if_b.o_bits),  32'h1);
    check("tie_error", 32'(if_b.o_error), 32'h1);

    // Word 9 after the reset; sync discards the 4 leftover chips.
    send_chips("111000000111", 0, 1'b1);
    check("after_rst_bits", 32'(if_a.o_bits), 32'h9);

    // Random traffic with occasional sync and reset.
    for (int n = 0; n < 1200; n++) begin
      logic v, s, r;
      v = ($urandom_range(99, 0) < 70);
      s = ($urandom_range(99, 0) < 2);
      r = ($urandom_range(199, 0) < 1);
      step(v, 1'($urandom), s, r);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
